// File: rtl/fadd_arbiter.sv
`default_nettype none
// ============================================================================
// fadd_arbiter : round-robin sharing of one single-issue FP adder by N lanes
// Revision     : 1.0
// ============================================================================
module fadd_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_x1,
    input  logic [32*N-1:0]   req_x2,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      resp_valid,
    output logic [31:0]       resp_y,
    output logic              resp_err,
    output logic [31:0]       fu_x1,
    output logic [31:0]       fu_x2,
    output logic              fu_ready,
    input  logic              fu_valid,
    input  logic [31:0]       fu_y,
    output logic              busy
);
    localparam int          c_IDW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned c_LASTI    = N - 1;
    localparam int unsigned c_WDI      = TIMEOUT - 1;
    localparam logic [c_IDW-1:0] c_LAST_RST = c_LASTI[c_IDW-1:0];
    localparam logic [7:0]  c_WD_LIM   = c_WDI[7:0];
    localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [c_IDW-1:0]   last_q;
    logic [c_IDW-1:0]   owner_q;
    logic [7:0]         wd_cnt_q;
    logic [31:0]        x1_q;
    logic [31:0]        x2_q;
    logic [31:0]        res_q;
    logic               err_q;
    logic               fu_ready_q;
    logic [N-1:0]       resp_valid_q;
    logic               busy_q;

    logic               grant_any;
    logic [c_IDW-1:0]   grant_id;
    logic [31:0]        grant_x1;
    logic [31:0]        grant_x2;
    logic [N-1:0]       grant_oh;
    logic [N-1:0]       owner_oh;

    // Second pass (lanes above last) overrides the wrap-around pass, and the
    // descending scan leaves the lowest index of each pass as the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_x1  = '0;
        grant_x2  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (i <= int'(last_q))) begin
                grant_any = 1'b1;
                grant_id  = i[c_IDW-1:0];
                grant_x1  = req_x1[32*i +: 32];
                grant_x2  = req_x2[32*i +: 32];
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(last_q))) begin
                grant_any = 1'b1;
                grant_id  = i[c_IDW-1:0];
                grant_x1  = req_x1[32*i +: 32];
                grant_x2  = req_x2[32*i +: 32];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        owner_oh = '0;
        for (int i = 0; i < N; i++) begin
            grant_oh[i] = (grant_id == i[c_IDW-1:0]);
            owner_oh[i] = (owner_q == i[c_IDW-1:0]);
        end
    end

    // Gated by rst so the accept strobe is silent while reset is held.
    assign req_ready = (state_q == S_IDLE && grant_any && !rst) ? grant_oh : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= c_LAST_RST;
            owner_q      <= '0;
            wd_cnt_q     <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            fu_ready_q   <= 1'b0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            fu_ready_q   <= 1'b0;
            resp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        x1_q       <= grant_x1;
                        x2_q       <= grant_x2;
                        owner_q    <= grant_id;
                        last_q     <= grant_id;
                        fu_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (fu_valid) begin
                        res_q        <= fu_y;
                        err_q        <= 1'b0;
                        resp_valid_q <= owner_oh;
                        state_q      <= S_RESP;
                    end else if (wd_cnt_q == c_WD_LIM) begin
                        res_q        <= c_QNAN;
                        err_q        <= 1'b1;
                        resp_valid_q <= owner_oh;
                        state_q      <= S_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fu_x1      = x1_q;
    assign fu_x2      = x2_q;
    assign fu_ready   = fu_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = res_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fadd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fadd_arbiter : directed + randomized bench with a transaction-level model
// Revision        : 1.0
// ============================================================================
module tb_fadd_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_x1;
    logic [32*N-1:0]   req_x2;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_y;
    logic              resp_err;
    logic [31:0]       fu_x1;
    logic [31:0]       fu_x2;
    logic              fu_ready;
    logic              fu_valid;
    logic [31:0]       fu_y;
    logic              busy;

    int          tests = 0;
    int          fails = 0;
    int          last_m;
    logic [31:0] last_y;
    bit          adder_on;
    bit          spur;

    always #5 clk = ~clk;

    fadd_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_y(resp_y), .resp_err(resp_err),
        .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_ready(fu_ready),
        .fu_valid(fu_valid), .fu_y(fu_y), .busy(busy)
    );

    // Stand-in adder: exact for the 1.0 + 2.0 case, integer sum elsewhere
    // (the arbiter only routes the value).
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    // Adder: result strobe two cycles after the cycle it sees fu_ready.
    logic        s1_q;
    logic [31:0] s1_y;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0; s1_y <= '0; fu_valid <= 1'b0; fu_y <= '0;
        end else begin
            s1_q     <= fu_ready & adder_on;
            s1_y     <= fadd_model(fu_x1, fu_x2);
            fu_valid <= s1_q | spur;
            fu_y     <= s1_q ? s1_y : 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_y"}, resp_y, 0);
        check({tag, "_resp_err"}, 32'(resp_err), 0);
        check({tag, "_fu_x1"}, fu_x1, 0);
        check({tag, "_fu_x2"}, fu_x2, 0);
        check({tag, "_fu_ready"}, 32'(fu_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
    endtask

    // Round-robin rule: first pending lane after the last winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++)
            if (m[(last_m + k) % N]) return (last_m + k) % N;
        return -1;
    endfunction

    // Called at a negedge with requests driven and the DUT idle; returns in
    // the response cycle. resp_at is the expected response cycle after accept.
    task automatic run_op(input int resp_at, input bit err, output int w);
        logic [31:0] a, b, ex_y;
        int          got_fu   = -1;
        int          got_resp = -1;
        logic        rr_bad   = 1'b0;
        w = rr_pick(req_valid);
        #1;
        check("accept_strobe", 32'(req_ready), 32'(1 << w));
        a    = req_x1[32*w +: 32];
        b    = req_x2[32*w +: 32];
        ex_y = err ? 32'h7FC0_0000 : fadd_model(a, b);
        @(posedge clk);
        last_m = w;
        for (int k = 1; k <= 40 && got_resp < 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[w] = 1'b0;
            #1;
            if (fu_ready && got_fu < 0) got_fu = k;
            if (req_ready != '0) rr_bad = 1'b1;
            if (k == 1) begin
                check("fu_x1", fu_x1, a);
                check("fu_x2", fu_x2, b);
                check("busy_issue", 32'(busy), 1);
            end
            if (resp_valid != '0) begin
                got_resp = k;
                last_y   = resp_y;
                check("resp_owner", 32'(resp_valid), 32'(1 << w));
                check("resp_y", resp_y, ex_y);
                check("resp_err", 32'(resp_err), 32'(err));
            end
        end
        check("fu_ready_cycle", 32'(got_fu), 1);
        check("resp_cycle", 32'(got_resp), 32'(resp_at));
        check("req_ready_quiet", 32'(rr_bad), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1; req_valid = '1; req_x1 = '0; req_x2 = '0;
        adder_on = 1'b1; spur = 1'b0; last_m = N - 1; last_y = '0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        req_valid = '0;
        rst       = 1'b0;
        @(negedge clk);

        // Single request from lane 0: 1.0 + 2.0
        set_lane(0, 1'b1, 32'h3F80_0000, 32'h4000_0000);
        run_op(4, 1'b0, w);
        check("single_grant", 32'(w), 0);
        check("single_sum", last_y, 32'h4040_0000);
        @(negedge clk);

        // Stray adder strobe while idle
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("spur_resp", 32'(resp_valid), 0);
            check("spur_busy", 32'(busy), 0);
            @(negedge clk);
        end

        // Reset during WAIT, then all four lanes continuously
        set_lane(2, 1'b1, $urandom, $urandom);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        #1;
        check("wait_busy", 32'(busy), 1);
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, $urandom, $urandom);
        rst = 1'b1;
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        rst    = 1'b0;
        last_m = N - 1;
        for (int n = 0; n < 5; n++) begin
            run_op(4, 1'b0, w);
            check("all4_order", 32'(w), 32'(n % 4));
            if (n < 4) set_lane(w, 1'b1, $urandom, $urandom);
            @(negedge clk);
        end
        req_valid = '0;

        // Lanes 1 and 3, lane 1 re-raised in its response cycle
        set_lane(1, 1'b1, $urandom, $urandom);
        set_lane(3, 1'b1, $urandom, $urandom);
        run_op(4, 1'b0, w);
        check("l13_order0", 32'(w), 1);
        set_lane(1, 1'b1, $urandom, $urandom);
        @(negedge clk);
        run_op(4, 1'b0, w);
        check("l13_order1", 32'(w), 3);
        @(negedge clk);
        run_op(4, 1'b0, w);
        check("l13_order2", 32'(w), 1);
        @(negedge clk);

        // Adder never answers: watchdog abort, then a normal operation
        adder_on = 1'b0;
        set_lane(2, 1'b1, $urandom, $urandom);
        run_op(2 + TIMEOUT, 1'b1, w);
        check("wd_result", last_y, 32'h7FC0_0000);
        adder_on = 1'b1;
        @(negedge clk);
        set_lane(0, 1'b1, $urandom, $urandom);
        run_op(4, 1'b0, w);
        @(negedge clk);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_lane(i, 1'b1, $urandom, $urandom);
            if (req_valid == '0) begin
                #1;
                check("idle_ready", 32'(req_ready), 0);
                check("idle_busy", 32'(busy), 0);
            end else if ($urandom_range(0, 5) == 0) begin
                adder_on = 1'b0;
                run_op(2 + TIMEOUT, 1'b1, w);
                adder_on = 1'b1;
            end else begin
                run_op(4, 1'b0, w);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fadd_arbiter.md
# fadd_arbiter

Round-robin arbiter that shares one single-issue floating-point adder (`x1`/`x2`/`y`, `ready`/`valid` handshake, one operation in flight, `valid` two cycles after the accepting `ready` cycle) among N requesters. It sits between the issue ports of several execution lanes and the adder instance. It latches operands and issues one operation at a time. It routes the result back to the owning requester and recovers from a missing `valid` with a watchdog.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 15: maximum WAIT cycles before a watchdog abort (1..255).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N: requester i has an operation pending; held until accepted.
- `req_x1` in 32*N: operand 1, lane i at bits [32i+31:32i].
- `req_x2` in 32*N: operand 2, same packing.
- `req_ready` out N: one-hot accept strobe, combinational, at most one bit high.
- `resp_valid` out N: one-hot one-cycle result strobe to the owner.
- `resp_y` out 32: result, valid while any `resp_valid` bit is high.
- `resp_err` out 1: high with `resp_valid` when the operation was aborted by the watchdog.
- `fu_x1` out 32: operand 1 to the adder, from the operand latch.
- `fu_x2` out 32: operand 2 to the adder, from the operand latch.
- `fu_ready` out 1: start strobe to the adder.
- `fu_valid` in 1: adder result strobe.
- `fu_y` in 32: adder result.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid` bit is high, grant by round-robin starting at `last+1` mod N.
  - Assert `req_ready[g]` in the same cycle.
  - Latch `req_x1[g]`, `req_x2[g]` and owner id g at the edge.
  - Set `last <= g` and go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE: `fu_ready=1` for exactly one cycle, then go to WAIT with the watchdog counter cleared.
- WAIT:
  - `fu_valid=1`: latch `fu_y` into the result register with err=0, then go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without `fu_valid`, load result 32'h7FC00000 with err=1, then go to RESP.
- RESP: `resp_valid[owner]=1`; `resp_y` and `resp_err` come from the result register. Go to IDLE.
- Operand latch and owner are stable from ISSUE through RESP. `fu_x1`/`fu_x2` always drive the latch.
- `fu_valid` outside WAIT is ignored: no state change, no response.
- `req_ready` is 0 in all states except IDLE. A requester may change or drop `req_valid` freely while it has not been granted.
- The arbiter does not inspect the operands. Zero, denormal and NaN handling are the adder's job.

## Timing
- Reset values:
  - State IDLE, `last=N-1` (requester 0 has first priority).
  - Watchdog counter, owner id, operand latch and result register all 0.
  - Outputs: `req_ready=0`, `resp_valid=0`, `resp_y=0`, `resp_err=0`, `fu_x1=0`, `fu_x2=0`, `fu_ready=0`, `busy=0`.
- Nominal sequence with accept in cycle T:
  - T: `req_ready` high.
  - T+1: `fu_ready` high.
  - T+3: `fu_valid` seen.
  - T+4: `resp_valid` high.
  - T+5: back in IDLE, next accept possible.
- Throughput is one operation per 5 cycles.
- Watchdog abort puts `resp_valid` at T+2+TIMEOUT.
- Simultaneous `req_valid` bits: only the round-robin winner is accepted. The losers keep waiting with `req_ready=0`.
- A requester whose response is in RESP may raise `req_valid` in that cycle; it is considered at T+5 in IDLE.
- `rst` asserted mid-operation clears everything immediately. The in-flight operation is dropped with no `resp_valid`. The adder's own reset must be tied so it also returns to its idle state.

## Test plan
- Single request: lane 0, x1=3F800000, x2=40000000; adder model returns 40400000 at T+3 → `req_ready[0]` at T, `fu_ready` at T+1, `resp_valid=0001`, `resp_y=40400000`, `resp_err=0` at T+4.
- All four lanes request continuously from reset → grant order 0,1,2,3,0, one grant every 5 cycles, each lane's response carries its own operands' sum.
- Lanes 1 and 3 request, and lane 1 is re-raised in its RESP cycle → grant order 1,3,1.
- Adder model never asserts `fu_valid`, TIMEOUT=15 → `resp_valid` at T+17 with `resp_y=7FC00000`, `resp_err=1`. The next request is issued normally.
- Spurious `fu_valid` pulse while in IDLE, with no request pending → no `resp_valid`, state remains IDLE.
- `rst` asserted in WAIT → all outputs 0 in that cycle, no response for the dropped operation. After release, the first grant goes to lane 0 when all lanes request.
